// File: rtl/image_padding_reader_pkg.sv
// Shared constants for the image padding reader: FSM state encodings and
// dimension/padding limits.
package image_padding_reader_pkg;

  localparam int DIM_BITS_DEF = 11;
  localparam int PAD_MAX      = 3;
  localparam int PAD_BITS     = $clog2(PAD_MAX + 1);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_TOP_PAD   = 4'd1;
  localparam logic [3:0] ST_WAIT_ROW  = 4'd2;
  localparam logic [3:0] ST_LEFT_PAD  = 4'd3;
  localparam logic [3:0] ST_READ_ROW  = 4'd4;
  localparam logic [3:0] ST_RIGHT_PAD = 4'd5;
  localparam logic [3:0] ST_ROW_END   = 4'd6;
  localparam logic [3:0] ST_BOT_PAD   = 4'd7;
  localparam logic [3:0] ST_FLUSH     = 4'd8;

endpackage

// File: rtl/image_padding_reader_pad_token_pipe.sv
// One-stage token pipe: registers the PAD/READ token flags and selects zero or
// the FIFO read data, which arrives one cycle after the read strobe.
module pad_token_pipe
  import image_padding_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_i,
  input  logic             read_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] fifo_dout_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  output logic             last_o
);

  logic valid_q, read_q, last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      read_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= pad_i | read_i;
      read_q  <= read_i;
      last_q  <= last_i;
    end
  end

  // FIFO data lands in the same cycle the registered READ flag does.
  assign dout_o       = read_q ? fifo_dout_i : '0;
  assign dout_valid_o = valid_q;
  assign last_o       = last_q;

endmodule

// File: rtl/image_padding_reader.sv
// Read side of the image padding FIFO: waits for a resident row, drains it and
// emits a zero-padded frame through a one-stage token pipe.
module image_padding_reader
  import image_padding_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11,
  parameter int DIM_BITS  = DIM_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIM_BITS-1:0]  row_num_i,
  input  logic [DIM_BITS-1:0]  col_num_i,
  input  logic [1:0]           pad_num_i,
  input  logic                 fifo_m_valid_i,
  input  logic [WIDTH-1:0]     fifo_dout_i,
  output logic                 fifo_rd_en_o,
  output logic [ADDR_BITS-1:0] fifo_m_count_o,
  output logic [WIDTH-1:0]     dout_o,
  output logic                 dout_valid_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);
  // state     | meaning
  // IDLE      | waiting for start
  // TOP_PAD   | pad_num*PC zero tokens
  // WAIT_ROW  | guard >= 2 cycles, then wait for a full row in the FIFO
  // LEFT_PAD  | pad_num zero tokens
  // READ_ROW  | col_num back-to-back FIFO reads
  // RIGHT_PAD | pad_num zero tokens
  // ROW_END   | advance row counter
  // BOT_PAD   | pad_num*PC zero tokens
  // FLUSH     | last beat leaves the pipe

  localparam int CNT = DIM_BITS + 2;

  logic [3:0]          state_q, state_d;
  logic [DIM_BITS-1:0] row_num_q, col_num_q;
  logic [PAD_BITS-1:0] pad_q;
  logic [CNT-1:0]      area_q, area_d;
  logic [CNT-1:0]      col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [CNT-1:0]      pad_m1, col_m1, row_m1, area_m1;
  logic                guard_q, guard_d, busy_q, busy_d;
  logic                latch_en, has_pad, last_row;
  logic                tok_pad, tok_read, tok_last;

  assign area_d   = CNT'(pad_num_i) * (CNT'(col_num_i) + CNT'({pad_num_i, 1'b0}));
  assign pad_m1   = CNT'(pad_q) - CNT'(1);
  assign col_m1   = CNT'(col_num_q) - CNT'(1);
  assign row_m1   = CNT'(row_num_q) - CNT'(1);
  assign area_m1  = area_q - CNT'(1);
  assign has_pad  = pad_q != '0;
  assign last_row = row_cnt_q == row_m1;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    guard_d   = guard_q;
    busy_d    = busy_q;
    latch_en  = 1'b0;
    tok_pad   = 1'b0;
    tok_read  = 1'b0;
    tok_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          latch_en  = 1'b1;
          busy_d    = 1'b1;
          col_cnt_d = '0;
          row_cnt_d = '0;
          guard_d   = 1'b0;
          state_d   = (pad_num_i != '0) ? ST_TOP_PAD : ST_WAIT_ROW;
        end
      end
      ST_TOP_PAD: begin
        tok_pad = 1'b1;
        if (col_cnt_q == area_m1) begin
          col_cnt_d = '0;
          guard_d   = 1'b0;
          state_d   = ST_WAIT_ROW;
        end else col_cnt_d = col_cnt_q + CNT'(1);
      end
      ST_WAIT_ROW: begin
        // fifo_m_valid may still describe the row just drained; skip one cycle.
        if (!guard_q) guard_d = 1'b1;
        else if (fifo_m_valid_i) begin
          col_cnt_d = '0;
          state_d   = has_pad ? ST_LEFT_PAD : ST_READ_ROW;
        end
      end
      ST_LEFT_PAD: begin
        tok_pad = 1'b1;
        if (col_cnt_q == pad_m1) begin
          col_cnt_d = '0;
          state_d   = ST_READ_ROW;
        end else col_cnt_d = col_cnt_q + CNT'(1);
      end
      ST_READ_ROW: begin
        tok_read = 1'b1;
        if (col_cnt_q == col_m1) begin
          col_cnt_d = '0;
          tok_last  = !has_pad && last_row;
          state_d   = has_pad ? ST_RIGHT_PAD : ST_ROW_END;
        end else col_cnt_d = col_cnt_q + CNT'(1);
      end
      ST_RIGHT_PAD: begin
        tok_pad = 1'b1;
        if (col_cnt_q == pad_m1) begin
          col_cnt_d = '0;
          state_d   = ST_ROW_END;
        end else col_cnt_d = col_cnt_q + CNT'(1);
      end
      ST_ROW_END: begin
        row_cnt_d = row_cnt_q + CNT'(1);
        guard_d   = 1'b0;
        if (last_row) state_d = has_pad ? ST_BOT_PAD : ST_FLUSH;
        else          state_d = ST_WAIT_ROW;
      end
      ST_BOT_PAD: begin
        tok_pad = 1'b1;
        if (col_cnt_q == area_m1) begin
          col_cnt_d = '0;
          tok_last  = 1'b1;
          state_d   = ST_FLUSH;
        end else col_cnt_d = col_cnt_q + CNT'(1);
      end
      ST_FLUSH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      guard_q   <= 1'b0;
      busy_q    <= 1'b0;
      row_num_q <= '0;
      col_num_q <= '0;
      pad_q     <= '0;
      area_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      guard_q   <= guard_d;
      busy_q    <= busy_d;
      if (latch_en) begin
        row_num_q <= row_num_i;
        col_num_q <= col_num_i;
        pad_q     <= pad_num_i;
        area_q    <= area_d;
      end
    end
  end

  assign fifo_rd_en_o   = tok_read;
  assign fifo_m_count_o = ADDR_BITS'(col_num_q);
  assign busy_o         = busy_q;

  pad_token_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pad_i        (tok_pad),
    .read_i       (tok_read),
    .last_i       (tok_last),
    .fifo_dout_i  (fifo_dout_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .last_o       (frame_done_o)
  );

endmodule

// File: tb/tb_image_padding_reader.sv
// Scoreboard bench for image_padding_reader with a behavioural FIFO and a
// frame-level padding reference model.
module tb_image_padding_reader;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [10:0] row_num, col_num;
  logic [1:0]  pad_num;
  logic        fifo_m_valid;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic [10:0] fifo_m_count;
  logic [7:0]  dout;
  logic        dout_valid, busy, frame_done;

  always #5 clk = ~clk;

  image_padding_reader #(.WIDTH(8), .ADDR_BITS(11), .DIM_BITS(11)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .row_num_i      (row_num),
    .col_num_i      (col_num),
    .pad_num_i      (pad_num),
    .fifo_m_valid_i (fifo_m_valid),
    .fifo_dout_i    (fifo_dout),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_m_count_o (fifo_m_count),
    .dout_o         (dout),
    .dout_valid_o   (dout_valid),
    .busy_o         (busy),
    .frame_done_o   (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         eol;
  } beat_t;

  beat_t      exp_q[$];
  int         frame_pix[$];
  logic [7:0] mem[$];
  logic [7:0] feed_q[$];
  int total = 0, bad = 0;
  int rd_total = 0, underflow = 0, beats_seen = 0, cyc = 0;
  bit have_prev = 0, prev_eol = 0;
  int prev_cyc = 0;

  // FIFO model: one write per cycle from feed_q; m_valid registered from the count.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mem.delete();
      feed_q.delete();
      fifo_m_valid <= 1'b0;
      fifo_dout    <= 8'h00;
    end else begin
      fifo_m_valid <= (mem.size() >= int'(fifo_m_count));
      if (fifo_rd_en) begin
        rd_total++;
        if (mem.size() == 0) underflow++;
        else fifo_dout <= mem.pop_front();
      end
      if (feed_q.size() > 0) mem.push_back(feed_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        beat_t e;
        beats_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got dout=%0d with empty scoreboard", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.data || frame_done !== e.last) begin
            bad++;
            $display("FAIL beat: got dout=%0d done=%0b expected dout=%0d done=%0b",
                     dout, frame_done, e.data, e.last);
          end
          if (have_prev && !prev_eol) begin
            total++;
            if (cyc != prev_cyc + 1) begin
              bad++;
              $display("FAIL row_gap: got beat at cycle %0d expected cycle %0d",
                       cyc, prev_cyc + 1);
            end
          end
          prev_eol  = e.eol;
          prev_cyc  = cyc;
          have_prev = 1;
        end
      end else if (frame_done) begin
        total++;
        bad++;
        $display("FAIL done_no_valid: got frame_done=1 expected 0 without dout_valid");
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: padded frame is PR x PC, zero outside the image window.
  task automatic build_frame(input int rows, input int cols, input int pad, input bit seq);
    int pr, pc;
    beat_t b;
    frame_pix.delete();
    for (int i = 0; i < rows * cols; i++)
      frame_pix.push_back(seq ? ((i + 1) % 256) : int'($urandom_range(0, 255)));
    pr = rows + 2 * pad;
    pc = cols + 2 * pad;
    for (int r = 0; r < pr; r++)
      for (int c = 0; c < pc; c++) begin
        if (r < pad || r >= pad + rows || c < pad || c >= pad + cols) b.data = 8'h00;
        else b.data = 8'(frame_pix[(r - pad) * cols + (c - pad)]);
        b.last = (r == pr - 1) && (c == pc - 1);
        b.eol  = (c == pc - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic start_frame(input int rows, input int cols, input int pad);
    row_num = 11'(rows);
    col_num = 11'(cols);
    pad_num = 2'(pad);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed_row(input int r, input int cols);
    for (int c = 0; c < cols; c++) feed_q.push_back(8'(frame_pix[r * cols + c]));
  endtask

  task automatic finish_frame(input int rows, input int cols, input int pad,
                              input int b0, input int r0);
    int n = 0;
    while (busy && n < 40000) begin
      tick();
      n++;
    end
    check("frame_timeout", int'(busy), 0);
    tick(2);
    check("beat_count", beats_seen - b0, (rows + 2 * pad) * (cols + 2 * pad));
    check("beats_left", exp_q.size(), 0);
    check("rd_count", rd_total - r0, rows * cols);
    check("underflow", underflow, 0);
    check("fifo_leftover", mem.size() + feed_q.size(), 0);
  endtask

  task automatic run_frame(input int rows, input int cols, input int pad, input bit seq,
                           input bit prefill, input int max_gap, input bit poke);
    int b0, r0;
    build_frame(rows, cols, pad, seq);
    b0 = beats_seen;
    r0 = rd_total;
    if (prefill) begin
      for (int r = 0; r < rows; r++) feed_row(r, cols);
      tick(rows * cols + 4);
    end
    start_frame(rows, cols, pad);
    if (poke) start_frame($urandom_range(1, 5), $urandom_range(1, 9), $urandom_range(0, 3));
    if (!prefill)
      for (int r = 0; r < rows; r++) begin
        feed_row(r, cols);
        tick($urandom_range(0, max_gap));
      end
    finish_frame(rows, cols, pad, b0, r0);
  endtask

  initial begin
    int b0, r0, b1, r1, n;
    rst = 1'b1; start = 1'b0; row_num = '0; col_num = '0; pad_num = '0;
    tick(3);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_m_count", int'(fifo_m_count), 0);
    check("rst_dout", int'(dout), 0);
    rst = 1'b0;
    tick(2);

    // 3x4 pad 1 with prefilled 1..12
    run_frame(3, 4, 1, 1, 1, 0, 0);
    // pad 0 passthrough
    run_frame(2, 5, 0, 0, 0, 3, 0);

    // second row arrives late: reader must hold in WAIT_ROW
    build_frame(2, 6, 1, 0);
    b0 = beats_seen;
    r0 = rd_total;
    start_frame(2, 6, 1);
    feed_row(0, 6);
    n = 0;
    while (rd_total - r0 < 6 && n < 200) begin
      tick();
      n++;
    end
    check("row1_drain", rd_total - r0, 6);
    tick(4);
    b1 = beats_seen;
    r1 = rd_total;
    tick(20);
    check("hold_rd", rd_total, r1);
    check("hold_beats", beats_seen, b1);
    check("hold_busy", int'(busy), 1);
    feed_row(1, 6);
    finish_frame(2, 6, 1, b0, r0);

    // widest row with maximum padding
    run_frame(1, 2047, 3, 0, 0, 0, 0);

    // reset in the middle of reading row 2
    build_frame(3, 6, 1, 0);
    r0 = rd_total;
    start_frame(3, 6, 1);
    for (int r = 0; r < 3; r++) feed_row(r, 6);
    n = 0;
    while (rd_total - r0 < 8 && n < 500) begin
      tick();
      n++;
    end
    check("reach_row2", rd_total - r0, 8);
    rst = 1'b1;
    tick();
    check("abort_rd_en", int'(fifo_rd_en), 0);
    check("abort_dout_valid", int'(dout_valid), 0);
    check("abort_busy", int'(busy), 0);
    rst = 1'b0;
    exp_q.delete();
    have_prev = 0;
    tick(2);
    run_frame(3, 6, 1, 0, 0, 2, 0);

    // start while busy must not disturb the running frame
    run_frame(3, 7, 2, 0, 0, 4, 1);

    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(1, 4), $urandom_range(1, 12), $urandom_range(0, 3),
                0, k[0], 6, k == 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
